// File: rtl/adc_sample_scheduler_pkg.sv
// Shared types and default sizes for the ADC sample path
// (ADC read controller -> sample scheduler -> PID core).
package adc_sample_scheduler_pkg;

    localparam int DEF_W_DATA = 18;
    localparam int DEF_N_CHAN = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/adc_sample_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo N (N must be a power of two).
module adc_sample_scheduler_rr_arbiter #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant,
    output logic         any
);

    logic [W-1:0] idx;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        // Scan from the farthest offset down so the nearest request wins last.
        for (int i = N - 1; i >= 0; i--) begin
            idx = ptr + W'(i);
            if (req[idx]) begin
                grant = idx;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_sample_scheduler.sv
// Buffers one sample per ADC channel and serialises pending, enabled
// channels onto a valid/ready stream with round-robin arbitration.
module adc_sample_scheduler
    import adc_sample_scheduler_pkg::*;
#(
    parameter int W_DATA = DEF_W_DATA,
    parameter int N_CHAN = DEF_N_CHAN,
    parameter int W_CHAN = $clog2(N_CHAN)
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic [N_CHAN-1:0]        adc_valid_in,
    input  logic signed [W_DATA-1:0] adc_a_in,
    input  logic signed [W_DATA-1:0] adc_b_in,
    input  logic [N_CHAN-1:0]        chan_en_in,
    input  logic                     update_in,
    input  logic                     pid_ready_in,
    output logic signed [W_DATA-1:0] pid_data_out,
    output logic [W_CHAN-1:0]        pid_chan_out,
    output logic                     pid_valid_out,
    output logic [N_CHAN-1:0]        overrun_out,
    input  logic                     overrun_clr_in
);

    localparam int HALF = N_CHAN / 2;

    state_t                   state, state_next;
    logic [N_CHAN-1:0]        en_cur;
    logic [N_CHAN-1:0]        pending, pending_next;
    logic [N_CHAN-1:0]        overrun_set;
    logic [W_CHAN-1:0]        ptr, grant;
    logic                     any_req, load, accept;
    logic signed [W_DATA-1:0] slot [N_CHAN];

    adc_sample_scheduler_rr_arbiter #(
        .N (N_CHAN),
        .W (W_CHAN)
    ) u_rr_arbiter (
        .req   (pending),
        .ptr   (ptr),
        .grant (grant),
        .any   (any_req)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    load       = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (pid_ready_in) begin
                    accept     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A capture landing on the channel being loaded re-arms it without an overrun,
    // and disabling a channel on update overrides everything else.
    always_comb begin
        pending_next = pending;
        overrun_set  = '0;
        for (int k = 0; k < N_CHAN; k++) begin
            if (load && grant == W_CHAN'(k)) pending_next[k] = 1'b0;
            if (adc_valid_in[k] && en_cur[k]) begin
                pending_next[k] = 1'b1;
                if (pending[k] && !(load && grant == W_CHAN'(k))) overrun_set[k] = 1'b1;
            end
            if (update_in && !chan_en_in[k]) pending_next[k] = 1'b0;
        end
    end

    assign pid_valid_out = (state == ST_ISSUE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state        <= ST_IDLE;
            pending      <= '0;
            overrun_out  <= '0;
            en_cur       <= '1;
            ptr          <= '0;
            pid_data_out <= '0;
            pid_chan_out <= '0;
        end else begin
            state       <= state_next;
            pending     <= pending_next;
            overrun_out <= (overrun_clr_in ? '0 : overrun_out) | overrun_set;
            if (update_in) en_cur <= chan_en_in;
            if (load) begin
                pid_data_out <= slot[grant];
                pid_chan_out <= grant;
            end
            if (accept) ptr <= pid_chan_out + W_CHAN'(1);
        end
    end

    for (genvar k = 0; k < N_CHAN; k++) begin : g_slot
        // NOTE: slot storage is reset explicitly so a post-reset dispatch never exposes stale data.
        always_ff @(posedge clk_in or posedge reset_in) begin
            if (reset_in) begin
                slot[k] <= '0;
            end else if (adc_valid_in[k]) begin
                slot[k] <= (k < HALF) ? adc_a_in : adc_b_in;
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Directed scoreboard bench: expected (chan, data) pairs are queued as
// stimulus is driven and compared at each valid/ready handshake.
module tb_adc_sample_scheduler;

    typedef struct {
        logic [2:0]  chan;
        logic [17:0] data;
    } sb_item_t;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [7:0]  adc_valid_in;
    logic [17:0] adc_a_in, adc_b_in;
    logic [7:0]  chan_en_in;
    logic        update_in;
    logic        pid_ready_in;
    logic [17:0] pid_data_out;
    logic [2:0]  pid_chan_out;
    logic        pid_valid_out;
    logic [7:0]  overrun_out;
    logic        overrun_clr_in;

    sb_item_t sb_q[$];
    int checks = 0;
    int errors = 0;

    adc_sample_scheduler dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .adc_valid_in   (adc_valid_in),
        .adc_a_in       (adc_a_in),
        .adc_b_in       (adc_b_in),
        .chan_en_in     (chan_en_in),
        .update_in      (update_in),
        .pid_ready_in   (pid_ready_in),
        .pid_data_out   (pid_data_out),
        .pid_chan_out   (pid_chan_out),
        .pid_valid_out  (pid_valid_out),
        .overrun_out    (overrun_out),
        .overrun_clr_in (overrun_clr_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch, input int d);
        sb_item_t it;
        it.chan = 3'(ch);
        it.data = 18'(d);
        sb_q.push_back(it);
    endtask

    // Runs with this cycle's inputs settled, just before the edge that consumes them.
    task automatic monitor();
        sb_item_t it;
        if (pid_valid_out && pid_ready_in) begin
            if (sb_q.size() == 0) begin
                check("unexpected_dispatch_sb_size", 32'(sb_q.size()), 32'd1);
            end else begin
                it = sb_q.pop_front();
                check("dispatch_chan", 32'(pid_chan_out), 32'(it.chan));
                check("dispatch_data", 32'(pid_data_out), 32'(it.data));
            end
        end
    endtask

    task automatic tick();
        monitor();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic cap(input logic [7:0] v, input int a, input int b);
        adc_valid_in = v;
        adc_a_in     = 18'(a);
        adc_b_in     = 18'(b);
        tick();
        adc_valid_in = '0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_sb_empty", 32'(sb_q.size()), 32'd0);
        tick();
        tick();
    endtask

    initial begin
        reset_in       = 1'b1;
        adc_valid_in   = '0;
        adc_a_in       = '0;
        adc_b_in       = '0;
        chan_en_in     = '0;
        update_in      = 1'b0;
        pid_ready_in   = 1'b0;
        overrun_clr_in = 1'b0;
        @(negedge clk_in);
        tick();
        check("rst_valid",   32'(pid_valid_out), 32'd0);
        check("rst_data",    32'(pid_data_out),  32'd0);
        check("rst_chan",    32'(pid_chan_out),  32'd0);
        check("rst_overrun", 32'(overrun_out),   32'd0);
        reset_in = 1'b0;
        tick();

        // Two halves captured together: chan 0 (a) then chan 4 (b).
        pid_ready_in = 1'b1;
        push(0, 100);
        push(4, -5);
        cap(8'h11, 100, -5);
        drain(20);

        // Fill all slots with 1..8 while downstream stalls.
        pid_ready_in = 1'b0;
        for (int j = 0; j < 8; j++) push(j, j + 1);
        for (int j = 0; j < 4; j++) cap(8'(1 << j) | 8'(1 << (j + 4)), j + 1, j + 5);
        repeat (10) tick();
        pid_ready_in = 1'b1;
        drain(40);
        check("fill_no_overrun", 32'(overrun_out), 32'd0);

        // Double capture of chan 2 behind a stalled chan 1.
        pid_ready_in = 1'b0;
        cap(8'h02, 50, 0);
        tick();
        cap(8'h04, 111, 0);
        cap(8'h04, 222, 0);
        check("overrun_ch2", 32'(overrun_out), 32'h04);
        push(1, 50);
        push(2, 222);
        pid_ready_in = 1'b1;
        drain(20);
        overrun_clr_in = 1'b1;
        tick();
        overrun_clr_in = 1'b0;
        check("overrun_cleared", 32'(overrun_out), 32'h00);

        // Clear coincident with a new chan-2 overrun; chan 3 must clear.
        pid_ready_in = 1'b0;
        cap(8'h02, 60, 0);
        tick();
        cap(8'h0C, 10, 0);
        cap(8'h0C, 20, 0);
        check("overrun_ch2_ch3", 32'(overrun_out), 32'h0C);
        overrun_clr_in = 1'b1;
        cap(8'h04, 30, 0);
        overrun_clr_in = 1'b0;
        check("overrun_set_wins", 32'(overrun_out), 32'h04);
        push(1, 60);
        push(2, 30);
        push(3, 20);
        pid_ready_in = 1'b1;
        drain(20);
        overrun_clr_in = 1'b1;
        tick();
        overrun_clr_in = 1'b0;
        check("overrun_cleared2", 32'(overrun_out), 32'h00);

        // Disable channels 4..7 while they are pending.
        pid_ready_in = 1'b0;
        cap(8'h01, 70, 0);
        tick();
        cap(8'hFE, 71, 81);
        chan_en_in = 8'h0F;
        update_in  = 1'b1;
        tick();
        update_in  = 1'b0;
        cap(8'h20, 0, 99);
        cap(8'h20, 0, 98);
        check("disabled_no_overrun", 32'(overrun_out), 32'h00);
        check("issue_held_chan",     32'(pid_chan_out), 32'd0);
        check("issue_held_data",     32'(pid_data_out), 32'd70);
        for (int j = 0; j < 4; j++) push(j, (j == 0) ? 70 : 71);
        pid_ready_in = 1'b1;
        drain(30);
        repeat (4) tick();
        check("disabled_idle", 32'(pid_valid_out), 32'd0);
        chan_en_in = 8'hFF;
        update_in  = 1'b1;
        tick();
        update_in  = 1'b0;

        // Fairness: after chan 6, chan 7 precedes chan 0.
        pid_ready_in = 1'b0;
        cap(8'h40, 0, 66);
        tick();
        cap(8'h81, 10, 77);
        push(6, 66);
        push(7, 77);
        push(0, 10);
        pid_ready_in = 1'b1;
        drain(20);

        // Reset while a sample is held in ISSUE.
        pid_ready_in = 1'b0;
        cap(8'h08, 33, 0);
        tick();
        check("issue_before_reset", 32'(pid_valid_out), 32'd1);
        check("issue_chan_3",       32'(pid_chan_out),  32'd3);
        reset_in = 1'b1;
        #1;
        check("midreset_valid",   32'(pid_valid_out), 32'd0);
        check("midreset_data",    32'(pid_data_out),  32'd0);
        check("midreset_chan",    32'(pid_chan_out),  32'd0);
        check("midreset_overrun", 32'(overrun_out),   32'd0);
        @(negedge clk_in);
        tick();
        reset_in = 1'b0;
        tick();
        check("post_reset_idle", 32'(pid_valid_out), 32'd0);
        pid_ready_in = 1'b1;
        push(2, -1);
        cap(8'h04, -1, 0);
        drain(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_sample_scheduler.md
# adc_sample_scheduler

Sits between the ADC serial-read controller and the PID core. Captures per-channel samples as the ADC read controller publishes them. Buffers one sample per channel and serializes enabled channels onto a single valid/ready stream using round-robin arbitration. Flags per-channel overruns when a buffered sample is overwritten before dispatch.

## Interface
Parameters:
- W_DATA, 18, sample width (signed)
- N_CHAN, 8, channel count; even, power of two, ≥2
- W_CHAN, 3, channel index width = log2(N_CHAN)

Ports:
- clk_in  input  1  system clock; all logic on its rising edge
- reset_in  input  1  asynchronous, active-high reset
- adc_valid_in  input  N_CHAN  one-hot-per-half valid from the ADC read controller
  - bit i captures adc_a_in into slot i, for i < N_CHAN/2
  - bit i+N_CHAN/2 captures adc_b_in into slot i+N_CHAN/2
- adc_a_in  input  W_DATA  signed channel-A sample
- adc_b_in  input  W_DATA  signed channel-B sample
- chan_en_in  input  N_CHAN  channel enable mask, applied on update
- update_in  input  1  single-cycle pulse; latches chan_en_in
- pid_ready_in  input  1  downstream accepts the sample
- pid_data_out  output  W_DATA  dispatched sample
- pid_chan_out  output  W_CHAN  channel index of pid_data_out
- pid_valid_out  output  1  sample valid
- overrun_out  output  N_CHAN  sticky per-channel overrun flags
- overrun_clr_in  input  1  pulse; clears overrun_out

## Operation
Capture:
- Every cycle, each set bit of adc_valid_in writes its slot buffer.
- A slot write sets pending[k] only if en_cur[k] = 1.
- If pending[k] is already set, overrun[k] is also set and the new data overwrites the slot.
- Captures to disabled channels still update the slot; no pending and no overrun.

Enable:
- On update_in, en_cur ← chan_en_in.
- In the same cycle, pending bits of newly disabled channels clear.
- A sample already in ST_ISSUE completes regardless of the new mask.

Dispatch FSM:
- ST_IDLE: if any pending bit is set, grant the first pending channel searching upward from ptr and wrapping modulo N_CHAN.
  - Load pid_data_out and pid_chan_out from that slot.
  - Clear pending[grant].
  - Go to ST_ISSUE.
- ST_ISSUE: pid_valid_out = 1 and the outputs are held stable.
  - On pid_ready_in: ptr ← grant+1 (wraps to 0), go to ST_IDLE.
- pid_valid_out is asserted only in ST_ISSUE.

Boundary conditions:
- Capture to channel k in the same cycle as its load in ST_IDLE: the load takes the old slot value; pending[k] stays 1 with the new value; no overrun.
- Capture to a channel while it is in ST_ISSUE: sets pending normally; held outputs do not change.
- overrun_clr_in in the same cycle as a new overrun: the set wins for that channel; all other channels clear.
- All pending bits clear: FSM remains in ST_IDLE and ptr is unchanged.

Reset values (asynchronous):
- FSM → ST_IDLE; pid_valid_out = 0; pid_data_out = 0; pid_chan_out = 0.
- overrun_out = 0; pending = 0; slot buffers = 0; ptr = 0.
- en_cur = all ones.
- Reset asserted mid-ISSUE drops pid_valid_out immediately.

## Timing
- Capture at edge E0 → slot/pending valid after E0.
- Load at edge E1 → pid_valid_out high after E1 (2-edge latency when idle).
- Max throughput is one sample per 2 cycles with pid_ready_in held high.
- Eight channels drain in 16 cycles, well inside the ADC conversion period.
- overrun_out updates at the edge following the offending capture.
- update_in takes effect for arbitration on the following cycle.

## Structure
- Shared package holds:
  - FSM state encodings: ST_IDLE, ST_ISSUE
  - default W_DATA/N_CHAN constants shared with the ADC read controller
- One natural sub-module: rr_arbiter (N-bit round-robin priority picker).
  - Inputs: request mask and pointer.
  - Outputs: grant index and any-grant flag. Purely combinational.

## Test plan
- Reset, then adc_valid_in = 0x11 with a = 100, b = -5; ready held high → (chan 0, 100) then (chan 4, -5); valid high one cycle each, 2 cycles apart.
- Fill all 8 slots with values 1..8; ready held low for 10 cycles, then high → dispatch order 0..7 with values unchanged; no overrun.
- Capture chan 2 twice before dispatch (ready low) → overrun_out = 0x04; dispatched value is the second sample. overrun_clr_in → 0x00. Clear coincident with a new chan-2 overrun → stays 0x04.
- update_in with chan_en_in = 0x0F while channels 4..7 are pending → those pending bits drop; only channels 0..3 are dispatched; chan 5 capture sets no overrun.
- Round-robin fairness: after granting chan 6, channels 0 and 7 are both pending → chan 7 first, then chan 0.
- Assert reset_in while in ST_ISSUE → pid_valid_out = 0 in the same cycle; all outputs at reset values; first post-reset capture dispatches normally.
